// File: rtl/add_round_key_serial.sv
// Byte-serial AddRoundKey: buffers one round key and one state block, then streams their XOR.
// Define ARK_ROUND_CNT_EN to add the round_num output (completed rounds, 0..NUM_ROUNDS).
module add_round_key_serial #(
   parameter int NBYTES = 16
`ifdef ARK_ROUND_CNT_EN
   ,
   parameter int NUM_ROUNDS = 10
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] key_in,
   input  logic       enable_key,
   input  logic [7:0] state_in,
   input  logic       enable_state,
   output logic [7:0] dout,
   output logic       enable_out,
   output logic       round_complete,
   output logic       busy
`ifdef ARK_ROUND_CNT_EN
   ,
   output logic [3:0] round_num
`endif
);

   localparam int CW = $clog2(NBYTES + 1);
   localparam int OW = $clog2(NBYTES);
   localparam logic [CW-1:0] FULL = CW'(NBYTES);
   localparam logic [OW-1:0] LAST = OW'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_OUT  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_kcnt;
   logic [CW-1:0]   w_kcnt_nxt;
   logic [CW-1:0]   r_scnt;
   logic [CW-1:0]   w_scnt_nxt;
   logic [OW-1:0]   r_ocnt;
   logic [OW-1:0]   w_ocnt_nxt;
   logic [7:0]      r_key_mem [NBYTES];
   logic [7:0]      r_st_mem  [NBYTES];
   logic            w_key_we;
   logic            w_st_we;
   logic [7:0]      r_dout;
   logic [7:0]      w_dout_nxt;
   logic            r_enable_out;
   logic            w_enable_out_nxt;
   logic            r_round_complete;
   logic            w_round_complete_nxt;
   logic            r_busy;
   logic            w_busy_nxt;

   // Next-state and next-output logic; all outputs are registered from these values.
   always_comb begin
      w_state_nxt          = r_state;
      w_kcnt_nxt           = r_kcnt;
      w_scnt_nxt           = r_scnt;
      w_ocnt_nxt           = r_ocnt;
      w_key_we             = 1'b0;
      w_st_we              = 1'b0;
      w_dout_nxt           = r_dout;
      w_enable_out_nxt     = 1'b0;
      w_round_complete_nxt = 1'b0;
      case (r_state)
         S_LOAD: begin
            if (enable_key && (r_kcnt < FULL)) begin
               w_key_we   = 1'b1;
               w_kcnt_nxt = r_kcnt + 1'b1;
            end
            if (enable_state && (r_scnt < FULL)) begin
               w_st_we    = 1'b1;
               w_scnt_nxt = r_scnt + 1'b1;
            end
            if ((r_kcnt == FULL) && (r_scnt == FULL)) begin
               w_state_nxt = S_OUT;
               w_ocnt_nxt  = '0;
            end
         end
         S_OUT: begin
            w_dout_nxt       = r_key_mem[r_ocnt] ^ r_st_mem[r_ocnt];
            w_enable_out_nxt = 1'b1;
            w_ocnt_nxt       = r_ocnt + 1'b1;
            if (r_ocnt == LAST) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_round_complete_nxt = 1'b1;
            w_kcnt_nxt           = '0;
            w_scnt_nxt           = '0;
            w_state_nxt          = S_LOAD;
         end
         default: begin
            w_state_nxt = S_LOAD;
            w_kcnt_nxt  = '0;
            w_scnt_nxt  = '0;
            w_ocnt_nxt  = '0;
         end
      endcase
   end

   // busy follows the FSM: registered from the state being entered.
   assign w_busy_nxt = (w_state_nxt != S_LOAD);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state          <= S_LOAD;
         r_kcnt           <= '0;
         r_scnt           <= '0;
         r_ocnt           <= '0;
         r_dout           <= '0;
         r_enable_out     <= 1'b0;
         r_round_complete <= 1'b0;
         r_busy           <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_kcnt           <= w_kcnt_nxt;
         r_scnt           <= w_scnt_nxt;
         r_ocnt           <= w_ocnt_nxt;
         r_dout           <= w_dout_nxt;
         r_enable_out     <= w_enable_out_nxt;
         r_round_complete <= w_round_complete_nxt;
         r_busy           <= w_busy_nxt;
      end
   end

   // Buffer contents need no reset; counters decide what is valid.
   always_ff @(posedge clk) begin
      if (w_key_we) begin
         r_key_mem[r_kcnt[OW-1:0]] <= key_in;
      end
      if (w_st_we) begin
         r_st_mem[r_scnt[OW-1:0]] <= state_in;
      end
   end

   assign dout           = r_dout;
   assign enable_out     = r_enable_out;
   assign round_complete = r_round_complete;
   assign busy           = r_busy;

`ifdef ARK_ROUND_CNT_EN
   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   logic [3:0] r_round_num;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_round_num <= '0;
      end else if (w_round_complete_nxt) begin
         r_round_num <= (r_round_num == LAST_ROUND) ? 4'd0 : r_round_num + 1'b1;
      end
   end

   assign round_num = r_round_num;
`endif

endmodule

// File: tb/tb_add_round_key_serial.sv
// Directed bench for add_round_key_serial: vector table plus hand-written corner sequences.
// Handshake: a byte is taken on a rising edge where its enable is high; outputs sampled at negedge.
module tb_add_round_key_serial;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] key_in;
   logic       enable_key;
   logic [7:0] state_in;
   logic       enable_state;
   logic [7:0] dout;
   logic       enable_out;
   logic       round_complete;
   logic       busy;
`ifdef ARK_ROUND_CNT_EN
   logic [3:0] round_num;
`endif

   add_round_key_serial dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .key_in         (key_in),
      .enable_key     (enable_key),
      .state_in       (state_in),
      .enable_state   (enable_state),
      .dout           (dout),
      .enable_out     (enable_out),
      .round_complete (round_complete),
      .busy           (busy)
`ifdef ARK_ROUND_CNT_EN
      ,
      .round_num      (round_num)
`endif
   );

   typedef struct {
      string      name;
      logic [7:0] k0;
      logic [7:0] ks;
      logic [7:0] s0;
      logic [7:0] ss;
      logic [7:0] e0;
      logic [7:0] es;
      int         mode;
   } vec_t;

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];
   int         n_rc = 0;
   int         burst_cnt = 0;
   int         n_starts = 0;
   int         burst_start = 0;
   int         last_out = 0;
   int         last_in = 0;
   logic       prev_en = 1'b0;
   int         rn_exp = 0;

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // scoreboard / monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         burst_cnt = 0;
         n_starts  = 0;
         prev_en   = 1'b0;
         rn_exp    = 0;
      end else begin
         if (enable_out) begin
            if (!prev_en) begin
               n_starts++;
               burst_start = cyc;
            end
            burst_cnt++;
            last_out = cyc;
            check("busy_during_out", int'(busy), 1);
            check("out_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) check("dout", int'(dout), int'(exp_q.pop_front()));
         end
         if (round_complete) begin
            n_rc++;
            check("rc_one_after_last_byte", last_out, cyc - 1);
            check("burst_len", burst_cnt, 16);
            check("burst_contiguous", n_starts, 1);
            check("rc_enable_out_low", int'(enable_out), 0);
`ifdef ARK_ROUND_CNT_EN
            rn_exp = (rn_exp == 10) ? 0 : rn_exp + 1;
            check("round_num", int'(round_num), rn_exp);
`endif
            burst_cnt = 0;
            n_starts  = 0;
         end
         prev_en = enable_out;
      end
   end

   // driver tasks (called at negedge + 1)
   task automatic send_cycle(input bit dk, input logic [7:0] kv, input bit ds, input logic [7:0] sv);
      enable_key   = dk;
      key_in       = dk ? kv : 8'($urandom);
      enable_state = ds;
      state_in     = ds ? sv : 8'($urandom);
      if (dk || ds) last_in = cyc + 1;
      @(negedge clk);
      #1;
   endtask

   task automatic inputs_off();
      enable_key   = 1'b0;
      enable_state = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) send_cycle(1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic push_exp(input logic [7:0] e0, input logic [7:0] es, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(e0 + es * 8'(i));
   endtask

   task automatic drive_block(input logic [7:0] k0, input logic [7:0] ks,
                              input logic [7:0] s0, input logic [7:0] ss, input int mode);
      int ki = 0;
      int si = 0;
      int c = 0;
      bit dk;
      bit ds;
      while (ki < 16 || si < 16) begin
         case (mode)
            1: begin dk = (ki < 16); ds = !dk && (si < 16); end
            2: begin dk = (c % 2 == 0) && (ki < 16); ds = (c % 2 == 1) && (si < 16); end
            3: begin dk = (c % 3 != 2) && (ki < 16); ds = (c % 4 != 1) && (si < 16); end
            default: begin dk = (ki < 16); ds = (si < 16); end
         endcase
         send_cycle(dk, k0 + ks * 8'(ki), ds, s0 + ss * 8'(si));
         if (dk) ki++;
         if (ds) si++;
         c++;
      end
      inputs_off();
   endtask

   task automatic finish_round(input string name, input int lin);
      int start = n_rc;
      int k = 0;
      while (n_rc == start && k < 80) begin
         @(negedge clk);
         #1;
         k++;
      end
      check({name, "_rc_count"}, n_rc - start, 1);
      check({name, "_latency"}, burst_start - lin, 2);
      check({name, "_queue_drained"}, exp_q.size(), 0);
   endtask

   task automatic run_vec(input vec_t v);
      push_exp(v.e0, v.es, 16);
      drive_block(v.k0, v.ks, v.s0, v.ss, v.mode);
      finish_round(v.name, last_in);
   endtask

   function automatic vec_t mk(input string n, input logic [7:0] k0, input logic [7:0] ks,
                               input logic [7:0] s0, input logic [7:0] ss,
                               input logic [7:0] e0, input logic [7:0] es, input int mode);
      vec_t v;
      v.name = n; v.k0 = k0; v.ks = ks; v.s0 = s0; v.ss = ss; v.e0 = e0; v.es = es; v.mode = mode;
      return v;
   endfunction

   initial begin
      vec_t vecs[6];
      int   lin;
      int   rc_before;
      int   k;

      // expected bytes hand-derived: e[i] = e0 + i*es
      vecs[0] = mk("fips",      8'h00, 8'h01, 8'h00, 8'h11, 8'h00, 8'h10, 0);
      vecs[1] = mk("aa55",      8'h55, 8'h00, 8'hAA, 8'h00, 8'hFF, 8'h00, 0);
      vecs[2] = mk("ff_ramp",   8'hFF, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 1);
      vecs[3] = mk("equal",     8'h3C, 8'h07, 8'h3C, 8'h07, 8'h00, 8'h00, 2);
      vecs[4] = mk("msb_even",  8'h80, 8'h00, 8'h00, 8'h02, 8'h80, 8'h02, 3);
      vecs[5] = mk("nib_hi",    8'h00, 8'h10, 8'h01, 8'h00, 8'h01, 8'h10, 2);

      // reset
      rst_n        = 1'b0;
      key_in       = 8'h00;
      enable_key   = 1'b0;
      state_in     = 8'h00;
      enable_state = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_dout", int'(dout), 0);
      check("reset_enable_out", int'(enable_out), 0);
      check("reset_round_complete", int'(round_complete), 0);
      check("reset_busy", int'(busy), 0);
`ifdef ARK_ROUND_CNT_EN
      check("reset_round_num", int'(round_num), 0);
`endif
      rst_n = 1'b1;
      idle(2);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);
      idle(3);
      check("idle_busy", int'(busy), 0);

      // skewed streams: state first, key later with a gap after byte 7
      push_exp(8'hFF, 8'h00, 16);
      for (int i = 0; i < 16; i++) send_cycle(1'b0, 8'h00, 1'b1, 8'hAA);
      idle(10);
      check("skew_no_out_state_only", int'(enable_out), 0);
      check("skew_not_busy", int'(busy), 0);
      for (int i = 0; i < 8; i++) send_cycle(1'b1, 8'h55, 1'b0, 8'h00);
      idle(3);
      check("skew_no_out_half_key", int'(enable_out), 0);
      for (int i = 0; i < 8; i++) send_cycle(1'b1, 8'h55, 1'b0, 8'h00);
      inputs_off();
      finish_round("skew", last_in);

      // overflow: 20 key bytes, extra traffic during OUT
      push_exp(8'h01, 8'h01, 16);
      lin = 0;
      for (int i = 0; i < 20; i++) begin
         send_cycle(1'b1, 8'(i + 1), (i < 16), 8'h00);
         if (i == 15) lin = last_in;
      end
      for (int i = 0; i < 5; i++) send_cycle(1'b1, 8'hEE, 1'b1, 8'hEE);
      inputs_off();
      finish_round("overflow", lin);
      push_exp(8'h20, 8'h01, 16);
      drive_block(8'h20, 8'h01, 8'h00, 8'h00, 3);
      finish_round("after_overflow", last_in);

      // reset in the middle of OUT, right after byte 5
      push_exp(8'h10, 8'h03, 6);
      drive_block(8'h10, 8'h03, 8'h00, 8'h00, 0);
      k = 0;
      while (burst_cnt < 6 && k < 80) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("rst_reached_byte5", burst_cnt, 6);
      rc_before = n_rc;
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      check("rst_mid_enable_out", int'(enable_out), 0);
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_round_complete", int'(round_complete), 0);
      check("rst_mid_dout", int'(dout), 0);
      rst_n = 1'b1;
      idle(20);
      check("rst_mid_no_rc", n_rc - rc_before, 0);
      check("rst_mid_queue", exp_q.size(), 0);
      run_vec(vecs[1]);

      // back-to-back rounds
      for (int r = 0; r < 3; r++) run_vec(vecs[(r + 2) % 6]);

`ifdef ARK_ROUND_CNT_EN
      rst_n = 1'b0;
      idle(2);
      check("rn_reset", int'(round_num), 0);
      rst_n = 1'b1;
      for (int r = 0; r < 12; r++) run_vec(vecs[r % 6]);
      check("rn_after_12", int'(round_num), 1);
`endif

      idle(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
